// File: rtl/if_pkg.sv
// if_pkg: shared fetch/decode types and constants.
package if_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INSTR_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/fetch_decode_queue_if.sv
// fetch_decode_queue_if: fetch-side and decode-side handshakes of the instruction queue.
interface fetch_decode_queue_if import if_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ADDR_W-1:0]        in_pc;
    logic [INSTR_W-1:0]       in_instr;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_pc;
    logic [INSTR_W-1:0]       out_instr;
    logic [$clog2(DEPTH):0]   count;
    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );
    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/queue_ptr.sv
// queue_ptr: wrapping queue pointer with increment and load-value clear.
module queue_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] clr_val,
    output logic [W-1:0] ptr
);
    logic [W-1:0] ptr_q, ptr_d;
    always_comb ptr_d = clr ? clr_val : inc ? ptr_q + W'(1) : ptr_q;
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
    assign ptr = ptr_q;
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: elastic {pc, instr} FIFO between fetch and decode with flush and NOP bubble.
module fetch_decode_queue import if_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    fetch_decode_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } pkt_t;
    pkt_t          mem_q [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, full;
    assign full = count_q == CW'(DEPTH);
    assign bus.in_ready = !rst && !bus.flush && !full;
    assign bus.out_valid = count_q != '0;
    assign push = bus.in_valid && bus.in_ready;
    assign pop = bus.out_valid && bus.out_ready;
    assign bus.count = count_q;
    assign bus.out_pc = bus.out_valid ? mem_q[rd_ptr].pc : '0;
    assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr].instr : INSTR_W'(NOP_INSTR);
    // flush drops the whole contents by snapping the read pointer onto the write pointer
    queue_ptr #(.W(PW)) u_rd (
        .clk(clk), .rst(rst), .inc(pop), .clr(bus.flush), .clr_val(wr_ptr), .ptr(rd_ptr)
    );
    queue_ptr #(.W(PW)) u_wr (
        .clk(clk), .rst(rst), .inc(push), .clr(1'b0), .clr_val('0), .ptr(wr_ptr)
    );
    always_comb begin
        count_d = bus.flush ? '0 :
                  (push && !pop) ? count_q + CW'(1) :
                  (pop && !push) ? count_q - CW'(1) : count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: table-driven directed checks of the fetch/decode instruction queue.
module tb_fetch_decode_queue;
    localparam logic [31:0] KEY = 32'hDEAD_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    fetch_decode_queue_if #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4)) bus ();
    fetch_decode_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    typedef struct {
        logic        r, f, iv, ordy;
        logic [31:0] pc;
        logic [2:0]  e_cnt;
        logic        e_ir, e_ov;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] pc, logic ordy,
                                logic [2:0] cnt, logic ir, logic ov, logic [31:0] epc);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.e_cnt = cnt; v.e_ir = ir; v.e_ov = ov; v.e_pc = epc;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic run(vec_t v, int idx);
        @(negedge clk);
        rst = v.r;
        bus.flush = v.f;
        bus.in_valid = v.iv;
        bus.in_pc = v.pc;
        bus.in_instr = v.pc ^ KEY;
        bus.out_ready = v.ordy;
        #1;
        chk("count", idx, 32'(bus.count), 32'(v.e_cnt));
        chk("in_ready", idx, 32'(bus.in_ready), 32'(v.e_ir));
        chk("out_valid", idx, 32'(bus.out_valid), 32'(v.e_ov));
        chk("out_pc", idx, bus.out_pc, v.e_pc);
        chk("out_instr", idx, bus.out_instr, v.e_ov ? (v.e_pc ^ KEY) : 32'h0000_0013);
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
        //                 r  f  iv pc      ordy cnt ir ov epc
        tbl.push_back(mk(1, 0, 0, 32'h00, 0, 0, 0, 0, 32'h00));
        tbl.push_back(mk(1, 0, 0, 32'h00, 0, 0, 0, 0, 32'h00));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h04, 0, 1, 1, 1, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h08, 0, 2, 1, 1, 32'h00));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 3, 1, 1, 32'h00));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 2, 1, 1, 32'h04));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 1, 32'h08));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h04, 0, 1, 1, 1, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h08, 0, 2, 1, 1, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h0C, 0, 3, 1, 1, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h10, 0, 4, 0, 1, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h10, 1, 4, 0, 1, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h10, 0, 3, 1, 1, 32'h04));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 4, 0, 1, 32'h04));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 3, 1, 1, 32'h08));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 2, 1, 1, 32'h0C));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 1, 32'h10));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h20, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h24, 0, 1, 1, 1, 32'h20));
        tbl.push_back(mk(0, 0, 1, 32'h28, 0, 2, 1, 1, 32'h20));
        tbl.push_back(mk(0, 1, 1, 32'h2C, 1, 3, 0, 1, 32'h20));
        tbl.push_back(mk(0, 0, 1, 32'h40, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 1, 1, 1, 32'h40));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 1, 32'h40));
        tbl.push_back(mk(0, 0, 1, 32'h50, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h54, 0, 1, 1, 1, 32'h50));
        tbl.push_back(mk(1, 1, 1, 32'h58, 1, 2, 0, 1, 32'h50));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 1, 32'h60, 0, 0, 1, 0, 32'h00));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 1, 32'h60));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 0, 1, 0, 32'h00));
        foreach (tbl[i]) run(tbl[i], i);
        // steady stream at occupancy 2 across several pointer wraps
        run(mk(0, 0, 1, 32'h200, 0, 0, 1, 0, 32'h000), 100);
        run(mk(0, 0, 1, 32'h204, 0, 1, 1, 1, 32'h200), 101);
        for (int k = 0; k < 20; k++)
            run(mk(0, 0, 1, 32'h208 + 32'(4 * k), 1, 2, 1, 1, 32'h200 + 32'(4 * k)), 200 + k);
        run(mk(0, 0, 0, 32'h000, 1, 2, 1, 1, 32'h250), 300);
        run(mk(0, 0, 0, 32'h000, 1, 1, 1, 1, 32'h254), 301);
        run(mk(0, 0, 0, 32'h000, 0, 0, 1, 0, 32'h000), 302);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
